// File: rtl/tpum_reg_bank_if.sv
// Bus bundle for the TPUM operand/accumulator register bank: one write port,
// a bulk clear and two registered read ports.
interface tpum_reg_bank_if #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
);
    logic              clr;
    logic              wr_en;
    logic              wr_acc;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd0_en;
    logic [ADDR_W-1:0] rd0_addr;
    logic              rd1_en;
    logic [ADDR_W-1:0] rd1_addr;
    logic [DATA_W-1:0] rd0_data;
    logic [DATA_W-1:0] rd1_data;
    logic              rd0_valid;
    logic              rd1_valid;
    logic              rd0_hit;
    logic              rd1_hit;
    logic              wr_err;

    modport master (
        output clr, wr_en, wr_acc, wr_addr, wr_data,
        output rd0_en, rd0_addr, rd1_en, rd1_addr,
        input  rd0_data, rd1_data, rd0_valid, rd1_valid, rd0_hit, rd1_hit, wr_err
    );

    modport slave (
        input  clr, wr_en, wr_acc, wr_addr, wr_data,
        input  rd0_en, rd0_addr, rd1_en, rd1_addr,
        output rd0_data, rd1_data, rd0_valid, rd1_valid, rd0_hit, rd1_hit, wr_err
    );
endinterface

// File: rtl/tpum_reg_bank.sv
// TPUM operand/accumulator register bank: NUM_REGS x DATA_W entries with
// load/accumulate writes, bulk clear, per-entry written flags and two
// registered read ports that forward the end-of-cycle entry state.
module tpum_reg_bank #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input logic            clk,
    input logic            rst,
    tpum_reg_bank_if.slave bus
);

    // Address is a legal entry index (NUM_REGS need not be a power of two).
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({{(32-ADDR_W){1'b0}}, a} < NUM_REGS);
    endfunction

    // Unsigned accumulate; the carry out is discarded so the sum wraps.
    function automatic logic [DATA_W-1:0] acc_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] s;
        s = a + b;
        return s;
    endfunction

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] wflag_q, wflag_d;
    logic                wr_err_q, wr_err_d;
    logic [DATA_W-1:0]   rd0_data_q, rd0_data_d, rd1_data_q, rd1_data_d;
    logic                rd0_valid_q, rd0_valid_d, rd1_valid_q, rd1_valid_d;
    logic                rd0_hit_q, rd0_hit_d, rd1_hit_q, rd1_hit_d;

    logic                wr_in;
    logic [ADDR_W-1:0]   widx;
    logic [DATA_W-1:0]   wr_new;

    // Write-port decode: safe index and the value a legal write would store.
    always_comb begin
        wr_in  = in_range(bus.wr_addr);
        widx   = wr_in ? bus.wr_addr : '0;
        wr_new = bus.wr_acc ? acc_wrap(mem_q[widx], bus.wr_data) : bus.wr_data;
    end

    // Next entry/flag state; clear wins over a same-cycle write.
    always_comb begin
        mem_d    = mem_q;
        wflag_d  = wflag_q;
        wr_err_d = 1'b0;
        if (bus.clr) begin
            mem_d   = '{default: '0};
            wflag_d = '0;
        end else if (bus.wr_en) begin
            if (wr_in) begin
                mem_d[widx]   = wr_new;
                wflag_d[widx] = 1'b1;
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    // Read ports sample the end-of-cycle state, which gives write-through
    // forwarding and clear visibility without extra bypass muxes.
    always_comb begin
        rd0_valid_d = bus.rd0_en;
        rd0_data_d  = rd0_data_q;
        rd0_hit_d   = rd0_hit_q;
        if (bus.rd0_en) begin
            if (in_range(bus.rd0_addr)) begin
                rd0_data_d = mem_d[bus.rd0_addr];
                rd0_hit_d  = wflag_d[bus.rd0_addr];
            end else begin
                rd0_data_d = '0;
                rd0_hit_d  = 1'b0;
            end
        end
        rd1_valid_d = bus.rd1_en;
        rd1_data_d  = rd1_data_q;
        rd1_hit_d   = rd1_hit_q;
        if (bus.rd1_en) begin
            if (in_range(bus.rd1_addr)) begin
                rd1_data_d = mem_d[bus.rd1_addr];
                rd1_hit_d  = wflag_d[bus.rd1_addr];
            end else begin
                rd1_data_d = '0;
                rd1_hit_d  = 1'b0;
            end
        end
    end

    // State and output registers; reset clears storage, flags and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q       <= '{default: '0};
            wflag_q     <= '0;
            wr_err_q    <= 1'b0;
            rd0_data_q  <= '0;
            rd1_data_q  <= '0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
            rd0_hit_q   <= 1'b0;
            rd1_hit_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wflag_q     <= wflag_d;
            wr_err_q    <= wr_err_d;
            rd0_data_q  <= rd0_data_d;
            rd1_data_q  <= rd1_data_d;
            rd0_valid_q <= rd0_valid_d;
            rd1_valid_q <= rd1_valid_d;
            rd0_hit_q   <= rd0_hit_d;
            rd1_hit_q   <= rd1_hit_d;
        end
    end

    assign bus.rd0_data  = rd0_data_q;
    assign bus.rd1_data  = rd1_data_q;
    assign bus.rd0_valid = rd0_valid_q;
    assign bus.rd1_valid = rd1_valid_q;
    assign bus.rd0_hit   = rd0_hit_q;
    assign bus.rd1_hit   = rd1_hit_q;
    assign bus.wr_err    = wr_err_q;

endmodule

// File: tb/tb_tpum_reg_bank.sv
// Directed bench for tpum_reg_bank with NUM_REGS=6, DATA_W=32 so that
// out-of-range addresses 6 and 7 exist.
module tb_tpum_reg_bank;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    tpum_reg_bank_if #(.NUM_REGS(6), .DATA_W(32)) bus ();

    tpum_reg_bank #(.NUM_REGS(6), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.clr      = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_acc   = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd0_en   = 1'b0;
        bus.rd0_addr = '0;
        bus.rd1_en   = 1'b0;
        bus.rd1_addr = '0;
    endtask

    // Advance one clock; outputs are inspected 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic acc, input logic [2:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_acc  = acc;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if ({bus.rd0_valid, bus.rd1_valid, bus.rd0_hit, bus.rd1_hit, bus.wr_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got %b exp 00000",
                     {bus.rd0_valid, bus.rd1_valid, bus.rd0_hit, bus.rd1_hit, bus.wr_err});
        end
        tests_run++;
        if (bus.rd0_data !== 32'h0 || bus.rd1_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data got %h/%h exp 0/0", bus.rd0_data, bus.rd1_data);
        end
        rst = 1'b0;
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd3;
        bus.rd1_en = 1'b1; bus.rd1_addr = 3'd3;
        step();
        idle();
        tests_run++;
        if ({bus.rd0_valid, bus.rd1_valid, bus.rd0_hit, bus.rd1_hit, bus.wr_err} !== 5'b11000) begin
            tests_failed++;
            $display("FAIL reset_read_flags got %b exp 11000",
                     {bus.rd0_valid, bus.rd1_valid, bus.rd0_hit, bus.rd1_hit, bus.wr_err});
        end
        tests_run++;
        if (bus.rd0_data !== 32'h0 || bus.rd1_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_read_data got %h/%h exp 0/0", bus.rd0_data, bus.rd1_data);
        end
    endtask

    task automatic test_load_acc_wrap();
        idle();
        wr(1'b0, 3'd2, 32'hFFFF_FFF0);
        step();
        wr(1'b1, 3'd2, 32'h0000_0020);
        step();
        idle();
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd2;
        step();
        idle();
        tests_run++;
        if (bus.rd0_data !== 32'h0000_0010 || bus.rd0_hit !== 1'b1 || bus.rd0_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL acc_wrap got data=%h hit=%b vld=%b exp 00000010/1/1",
                     bus.rd0_data, bus.rd0_hit, bus.rd0_valid);
        end
    endtask

    task automatic test_forwarding();
        idle();
        wr(1'b0, 3'd5, 32'hA5A5_0001);
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd5;
        step();
        idle();
        tests_run++;
        if (bus.rd0_data !== 32'hA5A5_0001 || bus.rd0_hit !== 1'b1) begin
            tests_failed++;
            $display("FAIL fwd_load got %h hit=%b exp a5a50001 hit=1", bus.rd0_data, bus.rd0_hit);
        end
        wr(1'b1, 3'd5, 32'h1);
        bus.rd1_en = 1'b1; bus.rd1_addr = 3'd5;
        step();
        idle();
        tests_run++;
        if (bus.rd1_data !== 32'hA5A5_0002 || bus.rd1_hit !== 1'b1) begin
            tests_failed++;
            $display("FAIL fwd_acc got %h hit=%b exp a5a50002 hit=1", bus.rd1_data, bus.rd1_hit);
        end
        tests_run++;
        if (bus.rd0_valid !== 1'b0 || bus.rd0_data !== 32'hA5A5_0001 || bus.rd0_hit !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd0_hold got vld=%b data=%h hit=%b exp 0/a5a50001/1",
                     bus.rd0_valid, bus.rd0_data, bus.rd0_hit);
        end
    endtask

    task automatic test_clear();
        idle();
        for (int i = 0; i < 6; i++) begin
            wr(1'b0, 3'(i), 32'h100 + 32'(i));
            step();
        end
        idle();
        bus.clr = 1'b1;
        wr(1'b0, 3'd1, 32'h55);
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd1;
        bus.rd1_en = 1'b1; bus.rd1_addr = 3'd4;
        step();
        idle();
        tests_run++;
        if (bus.rd0_data !== 32'h0 || bus.rd0_hit !== 1'b0 || bus.rd1_data !== 32'h0 || bus.rd1_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_fwd got %h/%b %h/%b exp 0/0 0/0",
                     bus.rd0_data, bus.rd0_hit, bus.rd1_data, bus.rd1_hit);
        end
        tests_run++;
        if (bus.wr_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_wr_err got %b exp 0", bus.wr_err);
        end
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd1;
        step();
        idle();
        tests_run++;
        if (bus.rd0_data !== 32'h0 || bus.rd0_hit !== 1'b0 || bus.rd0_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_after got %h hit=%b vld=%b exp 0/0/1",
                     bus.rd0_data, bus.rd0_hit, bus.rd0_valid);
        end
    endtask

    task automatic test_out_of_range();
        idle();
        wr(1'b0, 3'd0, 32'h77);
        step();
        wr(1'b0, 3'd7, 32'hDEAD);
        step();
        idle();
        tests_run++;
        if (bus.wr_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL oor_wr_err got %b exp 1", bus.wr_err);
        end
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd6;
        bus.rd1_en = 1'b1; bus.rd1_addr = 3'd0;
        step();
        idle();
        tests_run++;
        if (bus.wr_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL oor_wr_err_pulse got %b exp 0", bus.wr_err);
        end
        tests_run++;
        if (bus.rd0_valid !== 1'b1 || bus.rd0_data !== 32'h0 || bus.rd0_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL oor_read got vld=%b data=%h hit=%b exp 1/0/0",
                     bus.rd0_valid, bus.rd0_data, bus.rd0_hit);
        end
        tests_run++;
        if (bus.rd1_data !== 32'h77 || bus.rd1_hit !== 1'b1) begin
            tests_failed++;
            $display("FAIL oor_no_change got %h hit=%b exp 77 hit=1", bus.rd1_data, bus.rd1_hit);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addend [3];
        logic [31:0] expv   [3];
        addend = '{32'd1, 32'd2, 32'd3};
        expv   = '{32'd1, 32'd3, 32'd6};
        idle();
        for (int i = 0; i < 3; i++) begin
            wr(i != 0, 3'd3, addend[i]);
            bus.rd0_en = 1'b1; bus.rd0_addr = 3'd3;
            bus.rd1_en = 1'b1; bus.rd1_addr = 3'd3;
            step();
            tests_run++;
            if (bus.rd0_data !== expv[i] || bus.rd1_data !== expv[i]) begin
                tests_failed++;
                $display("FAIL b2b_acc[%0d] got %h/%h exp %h", i, bus.rd0_data, bus.rd1_data, expv[i]);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        wr(1'b0, 3'd0, 32'h10);
        step();
        for (int i = 0; i < 3; i++) begin
            wr(1'b1, 3'd0, 32'h5);
            bus.rd0_en = 1'b1; bus.rd0_addr = 3'd0;
            step();
        end
        tests_run++;
        if (bus.rd0_data !== 32'h1F || bus.rd0_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre got %h vld=%b exp 1f/1", bus.rd0_data, bus.rd0_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        tests_run++;
        if (bus.rd0_valid !== 1'b0 || bus.rd0_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_rst got vld=%b data=%h exp 0/0", bus.rd0_valid, bus.rd0_data);
        end
        bus.rd0_en = 1'b1; bus.rd0_addr = 3'd0;
        step();
        idle();
        tests_run++;
        if (bus.rd0_valid !== 1'b1 || bus.rd0_data !== 32'h0 || bus.rd0_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_after got vld=%b data=%h hit=%b exp 1/0/0",
                     bus.rd0_valid, bus.rd0_data, bus.rd0_hit);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        idle();
        test_reset();
        test_load_acc_wrap();
        test_forwarding();
        test_clear();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tpum_reg_bank.md
# tpum_reg_bank

Parametrised operand/accumulator register bank for the TPUM datapath. It generalises the fixed pair of enable-gated 32-bit registers to NUM_REGS entries of DATA_W bits. It has one write port with load or accumulate mode, two independent registered read ports with write-through forwarding, a single-cycle bulk clear, and per-entry "written" tracking. It sits between the TPUM control sequencer and the MAC array, holding operands and partial sums.

## Interface

- NUM_REGS, default 8: number of entries; legal range 2..256, need not be a power of two.
- DATA_W, default 32: entry width in bits; legal range 8..64.
- ADDR_W, default $clog2(NUM_REGS): address width; derived, do not override.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- clr  in  1  bulk clear of all entries and written flags.
- wr_en  in  1  write strobe.
- wr_acc  in  1  write mode; 0 = load wr_data, 1 = entry <= entry + wr_data.
- wr_addr  in  ADDR_W  write index.
- wr_data  in  DATA_W  write operand.
- rd0_en, rd1_en  in  1  read strobes, port 0 and port 1.
- rd0_addr, rd1_addr  in  ADDR_W  read indices.
- rd0_data, rd1_data  out  DATA_W  registered read data.
- rd0_valid, rd1_valid  out  1  registered; high one cycle after an accepted read.
- rd0_hit, rd1_hit  out  1  registered; entry had been written since the last reset or clear.
- wr_err  out  1  registered; pulses for one cycle when wr_en is issued with wr_addr >= NUM_REGS.

## Operation

- Storage: NUM_REGS x DATA_W entries plus NUM_REGS written flags.
- Write, when wr_en=1, clr=0 and wr_addr < NUM_REGS:
  - LOAD (wr_acc=0): entry <= wr_data.
  - ACC (wr_acc=1): entry <= (entry + wr_data) mod 2^DATA_W. The sum is unsigned and wraps, with no saturation and no carry out.
  - The entry's written flag is set to 1.
- Out-of-range write (wr_addr >= NUM_REGS): no state change; wr_err=1 next cycle.
- Clear: clr=1 zeroes every entry and every written flag. clr has priority over a same-cycle write; that write is dropped and wr_err stays 0.
- Read on port p with rdp_en=1:
  - Next cycle rdp_valid=1.
  - rdp_data = the entry value as of the end of the current cycle.
  - rdp_hit = that entry's written flag, also as of the end of the current cycle.
- Write-through forwarding:
  - A read of the address being written in the same cycle returns the post-write value: wr_data for LOAD, the wrapped sum for ACC. hit returns 1.
  - A read during clr returns data 0 and hit 0.
- Out-of-range read: valid=1, data=0, hit=0.
- rdp_en=0: valid=0 next cycle; rdp_data and rdp_hit hold their previous values.
- Both ports may read the same address in the same cycle; both return identical data.
- rst=1: all entries, flags and outputs go to 0. rst overrides clr, wr_en and rd_en.

## Timing

- Reset values: rd0_data=rd1_data=0, rd0_valid=rd1_valid=0, rd0_hit=rd1_hit=0, wr_err=0. All entries and written flags are 0.
- Write latency: the new value is visible to an array read issued in the next cycle. It is also visible to a same-cycle read through forwarding.
- Read latency: exactly 1 cycle from rdp_en to rdp_valid/rdp_data. Full throughput: one read per port per cycle, with no stalls and no backpressure.
- ACC back-to-back on the same address in consecutive cycles is legal; each cycle adds to the prior cycle's result.
- Reset mid-operation:
  - Reads accepted in the cycle rst is asserted are discarded; valid=0 the next cycle.
  - The first accepted operations are those in the cycle after rst deasserts.
- The output-to-input path is registered only; there are no combinational paths from inputs to outputs.

## Test plan

- Reset then read: reset, read addr 3 on both ports -> next cycle valid=1, data=0, hit=0; wr_err=0.
- LOAD/ACC wrap (DATA_W=32): LOAD addr 2 = 0xFFFF_FFF0, then ACC 0x20 -> read addr 2 returns 0x0000_0010, hit=1.
- Forwarding: same cycle, LOAD addr 5 = 0xA5A5_0001 plus rd0 addr 5 -> next cycle rd0_data=0xA5A5_0001, hit=1. Same cycle, ACC addr 5 += 1 plus rd1 addr 5 -> rd1_data=0xA5A5_0002.
- Clear priority: entries 0..7 loaded. clr=1 with a same-cycle LOAD addr 1 = 0x55 and a same-cycle rd0 addr 1 -> rd0_data=0, hit=0. Next read of addr 1 returns 0, hit=0; wr_err=0.
- Out of range (NUM_REGS=6): write addr 7 -> wr_err=1 for one cycle, no entry changes. Read addr 6 -> valid=1, data=0, hit=0.
- Reset mid-stream: back-to-back ACC on addr 0 with continuous reads, then rst asserted for one cycle -> next cycle valid=0 and data=0. Subsequent reads of addr 0 return 0 until rewritten.
